// File: rtl/sdm_bitstream_gen.sv
`default_nettype none
// ============================================================================
// Module  : sdm_bitstream_gen
// Brief   : Second-order single-bit delta-sigma modulator. Takes PCM samples
//           through valid/ready and emits one +1/-1 code per ce tick.
//           Optional macro SDM_DITHER_EN adds LFSR LSB dither to integrator 1.
// Revision: 1.0 - initial release
// ============================================================================
module sdm_bitstream_gen #(
    parameter int DW  = 16,
    parameter int OSR = 128,
    parameter int IW  = DW + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic signed [DW-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [1:0]           Xout,
    output logic                 xvalid,
    output logic                 underrun,
    output logic                 ovf
);
    localparam int PW = $clog2(OSR);
    localparam int SW = IW + 2;
    localparam logic [PW-1:0]        c_LAST = PW'(OSR - 1);
    localparam logic signed [SW-1:0] c_FS   = SW'(1) << (DW - 1);
    localparam logic signed [SW-1:0] c_MAX  = (SW'(1) << (IW - 1)) - SW'(1);
    localparam logic signed [SW-1:0] c_MIN  = -c_MAX;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [PW-1:0]        r_phase;
    logic signed [DW-1:0] r_pend;
    logic                 r_pend_full;
    logic signed [DW-1:0] r_hold;
    logic signed [IW-1:0] r_i1;
    logic signed [IW-1:0] r_i2;

    logic                 w_pos;
    logic signed [SW-1:0] w_x;
    logic signed [SW-1:0] w_i1e;
    logic signed [SW-1:0] w_i2e;
    logic signed [SW-1:0] w_fb;
    logic signed [SW-1:0] w_dith;
    logic signed [SW-1:0] w_s1;
    logic signed [SW-1:0] w_s2;
    logic signed [IW-1:0] w_i1n;
    logic signed [IW-1:0] w_i2n;
    logic                 w_sat1;
    logic                 w_sat2;

    assign din_ready = ~r_pend_full;

    // Sums are kept two bits wider than the integrators so clamping sees the true value
    assign w_pos = ~r_i2[IW-1];
    assign w_x   = {{(SW-DW){r_hold[DW-1]}}, r_hold};
    assign w_i1e = {{2{r_i1[IW-1]}}, r_i1};
    assign w_i2e = {{2{r_i2[IW-1]}}, r_i2};
    assign w_fb  = w_pos ? c_FS : -c_FS;
    assign w_s1  = w_i1e + w_x - w_fb + w_dith;
    assign w_s2  = w_i2e + w_i1e - w_fb;

`ifdef SDM_DITHER_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_dith    = r_lfsr[0] ? SW'(1) : {SW{1'b1}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= 16'hACE1;
        end else if (ce && (r_state == S_RUN)) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`else
    assign w_dith = '0;
`endif

    always_comb begin
        w_sat1 = 1'b0;
        w_sat2 = 1'b0;
        w_i1n  = w_s1[IW-1:0];
        w_i2n  = w_s2[IW-1:0];
        if (w_s1 > c_MAX) begin
            w_i1n  = c_MAX[IW-1:0];
            w_sat1 = 1'b1;
        end else if (w_s1 < c_MIN) begin
            w_i1n  = c_MIN[IW-1:0];
            w_sat1 = 1'b1;
        end
        if (w_s2 > c_MAX) begin
            w_i2n  = c_MAX[IW-1:0];
            w_sat2 = 1'b1;
        end else if (w_s2 < c_MIN) begin
            w_i2n  = c_MIN[IW-1:0];
            w_sat2 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_hold      <= '0;
            r_i1        <= '0;
            r_i2        <= '0;
            Xout        <= 2'b00;
            xvalid      <= 1'b0;
            underrun    <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            xvalid <= 1'b0;
            if (din_valid && !r_pend_full) begin
                r_pend      <= din;
                r_pend_full <= 1'b1;
            end
            if (ce) begin
                case (r_state)
                    S_IDLE: begin
                        if (r_pend_full) begin
                            r_hold      <= r_pend;
                            r_pend_full <= 1'b0;
                            r_phase     <= '0;
                            r_state     <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        r_i1   <= w_i1n;
                        r_i2   <= w_i2n;
                        Xout   <= w_pos ? 2'b01 : 2'b11;
                        xvalid <= 1'b1;
                        if (w_sat1 || w_sat2) begin
                            ovf <= 1'b1;
                        end
                        // An empty pending buffer at the boundary repeats the held sample
                        if (r_phase == c_LAST) begin
                            r_phase <= '0;
                            if (r_pend_full) begin
                                r_hold      <= r_pend;
                                r_pend_full <= 1'b0;
                            end else begin
                                underrun <= 1'b1;
                            end
                        end else begin
                            r_phase <= r_phase + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sdm_bitstream_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdm_bitstream_gen
// Brief   : Directed bench for sdm_bitstream_gen: per-frame code-sum table plus
//           reset, underrun and overload sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sdm_bitstream_gen;
    localparam int DW  = 16;
    localparam int OSR = 128;

    logic                 clk;
    logic                 rst;
    logic                 ce;
    logic signed [DW-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic [1:0]           Xout;
    logic                 xvalid;
    logic                 underrun;
    logic                 ovf;

    sdm_bitstream_gen #(.DW(DW), .OSR(OSR), .IW(DW + 4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .Xout      (Xout),
        .xvalid    (xvalid),
        .underrun  (underrun),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int din;
        int lo;
        int hi;
    } vec_t;

    vec_t       vecs [11];
    int         src_q[$];
    int         frame_sum [64];
    logic       frame_udr [64];
    logic [1:0] first_codes [4];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_codes, n_frames, n_acc, acc_sum, ce_cnt;
    logic       ce_en, ce_d, acc_last;

    task automatic chk(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic clear_bench();
        src_q.delete();
        n_codes = 0; n_frames = 0; n_acc = 0; acc_sum = 0; ce_cnt = 0;
        ce_en = 1'b0; ce_d = 1'b0; acc_last = 1'b0;
        ce = 1'b0; din_valid = 1'b0; din = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_bench();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Observe outputs of the previous posedge, then drive the next one
    task automatic step();
        int code;
        @(negedge clk);
        if (xvalid) begin
            chk("xvalid_one_clk_after_ce", int'(ce_d), 1, 1);
            code = (Xout == 2'b01) ? 1 : ((Xout == 2'b11) ? -1 : 0);
            chk("code_is_plus_or_minus_one", (code == 0) ? 0 : 1, 1, 1);
            if (n_codes < 4) first_codes[n_codes] = Xout;
            n_codes++;
            acc_sum += code;
            if ((n_codes % OSR) == 0 && n_frames < 64) begin
                frame_sum[n_frames] = acc_sum;
                frame_udr[n_frames] = underrun;
                n_frames++;
                acc_sum = 0;
            end
        end
        if (acc_last) chk("ready_low_after_accept", int'(din_ready), 0, 0);
        ce     = ce_en && (ce_cnt == 0);
        ce_cnt = (ce_cnt + 1) % 4;
        ce_d   = ce;
        if (src_q.size() > 0) begin
            din_valid = 1'b1;
            din       = DW'(src_q[0]);
        end else begin
            din_valid = 1'b0;
            din       = '0;
        end
        acc_last = din_valid && din_ready;
        if (acc_last) begin
            void'(src_q.pop_front());
            n_acc++;
        end
    endtask

    task automatic run_frames(input int target, input int budget);
        int cyc;
        cyc = 0;
        while (n_frames < target && cyc < budget) begin
            step();
            cyc++;
        end
        if (n_frames < target) chk("frame_timeout", n_frames, target, target);
    endtask

    task automatic chk_first_codes(input string tag);
        chk({tag, "_code0"}, int'(first_codes[0]), 1, 1);
        chk({tag, "_code1"}, int'(first_codes[1]), 3, 3);
        chk({tag, "_code2"}, int'(first_codes[2]), 3, 3);
        chk({tag, "_code3"}, int'(first_codes[3]), 1, 1);
    endtask

    initial begin
        // Zero-state trajectories: DC 0 has period 4, +-16384 return to zero state each frame
        vecs[0]  = '{0,      -1,   1};
        vecs[1]  = '{0,      -1,   1};
        vecs[2]  = '{0,      -1,   1};
        vecs[3]  = '{0,      -1,   1};
        vecs[4]  = '{16384,  62,  66};
        vecs[5]  = '{16384,  62,  66};
        vecs[6]  = '{-16384, -66, -62};
        vecs[7]  = '{-16384, -66, -62};
        vecs[8]  = '{8192,   28,  36};
        vecs[9]  = '{-8192,  -36, -28};
        vecs[10] = '{0,      -4,   4};

        rst = 1'b0;
        clear_bench();
        #12;
        chk("reset_xout",     int'(Xout),      0, 0);
        chk("reset_xvalid",   int'(xvalid),    0, 0);
        chk("reset_ready",    int'(din_ready), 1, 1);
        chk("reset_underrun", int'(underrun),  0, 0);
        chk("reset_ovf",      int'(ovf),       0, 0);
        @(negedge clk);
        rst = 1'b1;

        // Handshake works without ce; nothing else advances
        src_q.push_back(0);
        repeat (12) step();
        chk("no_code_without_ce", n_codes, 0, 0);
        chk("accept_without_ce", n_acc, 1, 1);
        chk("ready_held_low_without_ce", int'(din_ready), 0, 0);

        // Table of per-frame samples; one extra sample keeps the last boundary fed
        do_reset();
        foreach (vecs[k]) src_q.push_back(vecs[k].din);
        src_q.push_back(0);
        ce_en = 1'b1;
        run_frames(11, 8000);
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("frame%0d_sum_din%0d", k, vecs[k].din), frame_sum[k], vecs[k].lo, vecs[k].hi);
        end
        chk_first_codes("dc0");
        chk("table_all_accepted", n_acc, 12, 12);
        chk("table_no_underrun", int'(underrun), 0, 0);
        chk("table_no_ovf", int'(ovf), 0, 0);

        // Underrun: two samples, second one repeats
        do_reset();
        src_q.push_back(16384);
        src_q.push_back(-16384);
        ce_en = 1'b1;
        run_frames(3, 2000);
        chk("udr_frame0_flag", int'(frame_udr[0]), 0, 0);
        chk("udr_frame1_flag", int'(frame_udr[1]), 1, 1);
        chk("udr_frame0_sum", frame_sum[0], 62, 66);
        chk("udr_frame1_sum", frame_sum[1], -66, -62);
        chk("udr_frame2_repeat_sum", frame_sum[2], -66, -62);
        chk("udr_accept_count", n_acc, 2, 2);

        // Overload: integrator 2 clamps, output stays +1 without wrapping
        do_reset();
        repeat (3) src_q.push_back(32767);
        ce_en = 1'b1;
        run_frames(2, 1500);
        chk("ovl_ovf_set", int'(ovf), 1, 1);
        chk("ovl_frame1_all_plus", frame_sum[1], 128, 128);
        chk("ovl_no_underrun", int'(underrun), 0, 0);

        // Asynchronous reset mid-RUN, between clock edges
        #1 rst = 1'b0;
        #1;
        chk("midrst_xout",     int'(Xout),      0, 0);
        chk("midrst_xvalid",   int'(xvalid),    0, 0);
        chk("midrst_ready",    int'(din_ready), 1, 1);
        chk("midrst_ovf",      int'(ovf),       0, 0);
        chk("midrst_underrun", int'(underrun),  0, 0);
        clear_bench();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ce_en = 1'b1;
        repeat (40) step();
        chk("post_reset_idle_no_code", n_codes, 0, 0);
        src_q.push_back(0);
        src_q.push_back(0);
        run_frames(1, 1000);
        chk_first_codes("post_reset");
        chk("post_reset_frame_sum", frame_sum[0], -1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
